// File: rtl/oam_sprite_scanner.sv
// oam_sprite_scanner: per-scanline sprite evaluator on the OAM read side.
// Scans all OAM entries after a start pulse, keeps up to MAX_SPRITES entries
// that cover the requested scanline (flagging overflow beyond that), then
// streams the kept entries in OAM order over a valid/ready handshake.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, scanline,     evaluation request; scanline/sprite_tall latched with start
//   sprite_tall
//   oam_read_addr/data   OAM read port (data belongs to the address currently issued)
//   busy, done, overflow status; done pulses once when scan and drain finish
//   out_valid/ready      selected-entry stream with out_entry, out_row, out_last
module oam_sprite_scanner #(
   parameter int unsigned NUM_ENTRIES = 64,
   parameter int unsigned MAX_SPRITES = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  scanline,
   input  logic        sprite_tall,
   output logic [5:0]  oam_read_addr,
   input  logic [31:0] oam_read_data,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_entry,
   output logic [3:0]  out_row,
   output logic        out_last
);

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned CNT_W  = $clog2(MAX_SPRITES + 1);
   localparam int unsigned IDX_W  = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t           state;
   logic [7:0]       line_q;
   logic             tall_q;
   logic [CNT_W-1:0] count;
   logic [IDX_W-1:0] rd_idx;

   logic [31:0]      buf_entry [MAX_SPRITES];
   logic [3:0]       buf_row   [MAX_SPRITES];

   // Hit test on the entry currently returned by OAM (modular row distance)
   logic [7:0]       diff_c;
   logic             hit_c;
   logic             room_c;
   logic             store_c;
   logic [CNT_W-1:0] count_nxt_c;
   logic [IDX_W-1:0] nxt_idx_c;

   always_comb begin
      diff_c      = line_q - oam_read_data[15:8];
      hit_c       = diff_c < (tall_q ? 8'd16 : 8'd8);
      room_c      = count < CNT_W'(MAX_SPRITES);
      store_c     = (state == SCAN) && hit_c && room_c;
      count_nxt_c = count + CNT_W'(store_c);
      nxt_idx_c   = rd_idx + IDX_W'(1);
   end

   // Selection buffer: data-only storage, no reset needed
   always_ff @(posedge clk) begin
      if (store_c) begin
         buf_entry[count[IDX_W-1:0]] <= oam_read_data;
         buf_row[count[IDX_W-1:0]]   <= diff_c[3:0];
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         line_q        <= '0;
         tall_q        <= 1'b0;
         count         <= '0;
         rd_idx        <= '0;
         oam_read_addr <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         out_valid     <= 1'b0;
         out_entry     <= '0;
         out_row       <= '0;
         out_last      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  line_q        <= scanline;
                  tall_q        <= sprite_tall;
                  count         <= '0;
                  overflow      <= 1'b0;
                  oam_read_addr <= '0;
                  busy          <= 1'b1;
                  state         <= SCAN;
               end
            end
            SCAN: begin
               count <= count_nxt_c;
               if (hit_c && !room_c) overflow <= 1'b1;
               oam_read_addr <= oam_read_addr + ADDR_W'(1);
               if (oam_read_addr == LAST_ADDR) begin
                  oam_read_addr <= '0;
                  if (count_nxt_c != '0) begin
                     state     <= DRAIN;
                     out_valid <= 1'b1;
                     rd_idx    <= '0;
                     out_last  <= (count_nxt_c == CNT_W'(1));
                     // A sole hit on the final entry is not in the buffer yet
                     if (count == '0) begin
                        out_entry <= oam_read_data;
                        out_row   <= diff_c[3:0];
                     end else begin
                        out_entry <= buf_entry[0];
                        out_row   <= buf_row[0];
                     end
                  end else begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            DRAIN: begin
               // out_valid is held high for the whole of DRAIN
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     rd_idx    <= nxt_idx_c;
                     out_entry <= buf_entry[nxt_idx_c];
                     out_row   <= buf_row[nxt_idx_c];
                     out_last  <= (CNT_W'(nxt_idx_c) + CNT_W'(1) == count);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oam_sprite_scanner.sv
// Scoreboard bench for oam_sprite_scanner: a reference model computes the
// selected entries from the OAM contents; a monitor pops and compares them.
module tb_oam_sprite_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  scanline;
   logic        sprite_tall;
   logic [5:0]  oam_read_addr;
   logic [31:0] oam_read_data;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_entry;
   logic [3:0]  out_row;
   logic        out_last;

   typedef struct packed {
      logic [31:0] entry;
      logic [3:0]  row;
      logic        last;
   } exp_t;

   logic [31:0] mem [64];
   exp_t        exp_q [$];
   exp_t        mon_e;
   exp_t        prev_out;
   logic        prev_stall = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          done_seen = 0;

   always #5 clk = ~clk;

   // OAM model: the DUT's registered address acts as the RAM address register
   assign oam_read_data = mem[oam_read_addr];

   oam_sprite_scanner dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .scanline      (scanline),
      .sprite_tall   (sprite_tall),
      .oam_read_addr (oam_read_addr),
      .oam_read_data (oam_read_data),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_entry     (out_entry),
      .out_row       (out_row),
      .out_last      (out_last)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference: walk OAM in index order applying the selection rules
   task automatic model(input logic [7:0] line, input bit tall,
                        output bit ovf, output int ovf_cyc, output int nhits);
      int   h;
      logic [7:0] d;
      exp_t e;
      h = 0; ovf = 1'b0; ovf_cyc = -1;
      for (int k = 0; k < 64; k++) begin
         d = line - mem[k][15:8];
         if (int'(d) < (tall ? 16 : 8)) begin
            h++;
            if (h <= 8) begin
               e.entry = mem[k]; e.row = d[3:0]; e.last = 1'b0;
               exp_q.push_back(e);
            end else if (h == 9) begin
               ovf = 1'b1;
               ovf_cyc = k + 2;   // rises at edge E+k+1, seen in sample k+2
            end
         end
      end
      nhits = (h > 8) ? 8 : h;
      if (nhits > 0) begin
         e = exp_q.pop_back();
         e.last = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic fill_y(input logic [7:0] y);
      for (int k = 0; k < 64; k++)
         mem[k] = {8'($urandom), 8'($urandom), y, 8'($urandom)};
   endtask

   task automatic set_y(input int k, input logic [7:0] y);
      mem[k][15:8] = y;
   endtask

   // Monitor: scoreboard pop on handshake, hold stability, done qualification
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("hold_stable", {out_valid, out_entry, out_row, out_last}, {1'b1, prev_out});
         if (done) begin
            done_seen++;
            check("done_idle", {out_valid, busy}, 2'b00);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_out");
            else begin
               mon_e = exp_q.pop_front();
               check("out_data", {out_entry, out_row, out_last}, mon_e);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_entry, out_row, out_last};
      end
   end

   // ready_mode: 0 always ready, 1 random, 2 stall 5 valid cycles then ready
   task automatic run_scan(input logic [7:0] line, input bit tall,
                           input int ready_mode, input bit mid_start);
      bit exp_ovf;
      int ovf_cyc, nhits, cyc, first_valid, ovf_seen, done_cyc, stall, d0;
      model(line, tall, exp_ovf, ovf_cyc, nhits);
      d0 = done_seen; first_valid = -1; ovf_seen = -1; done_cyc = -1; stall = 0; cyc = 0;
      scanline = line; sprite_tall = tall; start = 1'b1;
      out_ready = (ready_mode == 0);
      while (done_cyc < 0 && cyc < 600) begin
         @(posedge clk); #1;
         cyc++;
         start = mid_start && (cyc == 20);
         if (cyc == 1) check("start_clears_ovf", overflow, 1'b0);
         if (cyc <= 64) check("addr_busy", {busy, oam_read_addr}, {1'b1, 6'(cyc - 1)});
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (overflow && ovf_seen < 0) ovf_seen = cyc;
         if (done) done_cyc = cyc;
         case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (stall >= 5) out_ready = 1'b1;
               else if (out_valid) stall++;
            end
         endcase
      end
      if (done_cyc < 0) begin
         fail_now("done_timeout");
         exp_q.delete();
      end else begin
         check("overflow_rise", ovf_seen, ovf_cyc);
         if (nhits == 0) begin
            check("done_lat_nohit", done_cyc, 65);
            check("no_valid", first_valid, -1);
         end else begin
            check("first_valid_lat", first_valid, 65);
            if (ready_mode == 0) check("done_lat_hits", done_cyc, 65 + nhits);
         end
      end
      repeat (3) begin @(posedge clk); #1; end
      check("done_once", done_seen - d0, 1);
      check("scoreboard_empty", exp_q.size(), 0);
      check("ovf_held_idle", {overflow, busy}, {exp_ovf, 1'b0});
      out_ready = 1'b0;
   endtask

   task automatic run_reset_mid();
      int d0;
      fill_y(8'hF0);
      for (int k = 0; k < 10; k++) set_y(k, 8'd40);
      d0 = done_seen;
      scanline = 8'd44; sprite_tall = 1'b0; out_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (29) begin @(posedge clk); #1; end
      check("pre_reset_state", {busy, overflow, oam_read_addr}, {2'b11, 6'd29});
      #2 rst_n = 1'b0;
      #1 check("reset_async", {oam_read_addr, busy, done, overflow, out_valid, out_entry, out_row, out_last}, '0);
      repeat (3) begin @(posedge clk); #1; end
      check("reset_hold", {oam_read_addr, busy, done, overflow, out_valid, out_entry, out_row, out_last}, '0);
      rst_n = 1'b1;
      repeat (80) begin @(posedge clk); #1; end
      check("no_done_after_reset", done_seen - d0, 0);
      check("idle_after_reset", {busy, out_valid}, 2'b00);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] line;
      bit         tall;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; scanline = '0; sprite_tall = 1'b0;
      fill_y(8'hF0);
      #12;
      check("reset_values", {oam_read_addr, busy, done, overflow, out_valid, out_entry, out_row, out_last}, '0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // No hits anywhere
      fill_y(8'hF0);
      run_scan(8'd10, 1'b0, 0, 1'b0);

      // Three scattered hits, row 3 each
      fill_y(8'hF0);
      set_y(5, 8'd10); set_y(20, 8'd10); set_y(63, 8'd10);
      run_scan(8'd13, 1'b0, 0, 1'b0);

      // Ten hits: first eight kept, overflow on the ninth
      fill_y(8'hF0);
      for (int k = 0; k < 10; k++) set_y(k, 8'd40);
      run_scan(8'd44, 1'b0, 0, 1'b0);

      // Tall sprite bottom row, short sprite miss, wrap-around
      fill_y(8'hF0);
      set_y(3, 8'd100);
      run_scan(8'd115, 1'b1, 0, 1'b0);
      run_scan(8'd115, 1'b0, 0, 1'b0);
      fill_y(8'hF0);
      set_y(3, 8'd250);
      run_scan(8'd2, 1'b1, 0, 1'b0);

      // Backpressure on the first of two entries
      fill_y(8'hF0);
      set_y(7, 8'd50); set_y(30, 8'd52);
      run_scan(8'd55, 1'b0, 2, 1'b0);

      // Start pulsed during the scan
      fill_y(8'hF0);
      set_y(2, 8'd60); set_y(40, 8'd57); set_y(41, 8'd63);
      run_scan(8'd63, 1'b0, 0, 1'b1);

      // Reset mid-scan, then a normal scan
      run_reset_mid();
      fill_y(8'hF0);
      set_y(11, 8'd20); set_y(12, 8'd27);
      run_scan(8'd27, 1'b0, 0, 1'b0);

      // Randomised tables with random backpressure
      for (int it = 0; it < 12; it++) begin
         line = 8'($urandom);
         tall = 1'($urandom_range(0, 1));
         for (int k = 0; k < 64; k++) begin
            mem[k] = $urandom;
            if ($urandom_range(0, 3) == 0) set_y(k, line - 8'($urandom_range(0, 17)));
         end
         run_scan(line, tall, 1, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
